fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the dual-port instruction ROM.
- Owns the PC and drives one ROM port's address and enable (port A; port B is free for data reads).
- Tracks the ROM's 1-cycle registered read latency and presents {instr, pc, fault} to decode over a valid/ready handshake.
- Handles stall back-pressure, branch redirect, halt and out-of-range fetch.

Parameters:
- WIDTH, 32, data/address width in bits; addresses are byte addresses, word aligned.
- LENGTH, 256, ROM depth in words; legal fetch range is 0 .. LENGTH*4-4.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- rom_en  out  1  ROM port enable (to en_a).
- rom_addr  out  WIDTH  ROM byte address (to addr_a).
- rom_rd  in  WIDTH  ROM read data (from rd_a); valid the cycle after rom_en=1, held while rom_en=0.
- redirect_valid  in  1  branch/jump redirect request.
- redirect_pc  in  WIDTH  redirect target; bits [1:0] are ignored (treated as 0).
- halt_req  in  1  level; stop fetching new instructions.
- out_valid  out  1  fetched instruction available.
- out_ready  in  1  decode accepts this cycle.
- out_instr  out  WIDTH  instruction (= rom_rd pass-through).
- out_pc  out  WIDTH  byte address of out_instr.
- out_fault  out  1  out_instr came from an out-of-range address.
- halted  out  1  unit is in HALT.

Behaviour:
- Handshake and issue:
  - Transfer occurs when out_valid & out_ready.
  - Internal regs: fetch_pc, resp_pc, resp_valid, resp_fault, state.
- States:
  - RUN: normal fetching.
  - DRAIN: no new issue; waits for resp_valid=0.
  - HALT: idle.
- Reset (async, rst_n=0):
  - state=RUN, fetch_pc=RESET_PC, resp_valid=0, resp_pc=RESET_PC, resp_fault=0.
  - Outputs during reset: rom_en=0, out_valid=0, out_fault=0, halted=0.
  - First issue happens in the first clock edge with rst_n=1.
- Issue rule in RUN: can_issue = !resp_valid | out_ready.
  - rom_en = can_issue, rom_addr = fetch_pc.
  - On issue: fetch_pc <= fetch_pc+4 (mod 2^WIDTH), resp_valid <= 1, resp_pc <= fetch_pc, resp_fault <= (fetch_pc >= LENGTH*4).
  - Else, if out_ready: resp_valid <= 0.
  - If not issuing and out_ready=0: registers hold. The ROM holds rd while en=0, so out_instr stays stable under stall.
- Latency:
  - Issue in cycle N gives out_valid in cycle N+1 with out_pc=A.
  - Throughput is 1 instruction/cycle with out_ready held high.
- Outputs:
  - out_valid = resp_valid & !redirect_valid.
  - out_instr = rom_rd, out_pc = resp_pc, out_fault = resp_fault.
- Redirect (highest priority, any state):
  - rom_en=1, rom_addr={redirect_pc[WIDTH-1:2],2'b00}.
  - Next: resp_pc <= that address, resp_valid <= 1, fetch_pc <= address+4, state <= RUN.
  - Any pending response is squashed: out_valid=0 in the redirect cycle even if out_ready=1.
- Halt and fault:
  - In RUN with halt_req=1 (no redirect): no issue; state <= DRAIN.
  - An issue whose fault bit is set also moves to DRAIN after that issue.
  - DRAIN: rom_en=0; existing response handshakes normally; when resp_valid=0 (or is consumed this cycle), state <= HALT.
  - HALT: rom_en=0, out_valid=0, halted=1; exit only via redirect. halt_req deassertion alone does not resume.
- Boundaries:
  - fetch_pc wraps 0xFFFFFFFC -> 0.
  - Simultaneous redirect+halt_req: redirect wins and state=RUN. If halt_req is still high next cycle, the unit drains after delivering the redirect target.
  - rst_n assertion mid-stall discards the pending response immediately.

Test Plan:
- Reset release, out_ready=1, ROM word i = 0x1000+i → rom_en=1 at cycle 0 with addr 0; out_valid from cycle 1 with (pc,instr) = (0,0x1000), (4,0x1001), (8,0x1002); one per cycle.
- Stall: out_ready=0 for 3 cycles while out_pc=8 → rom_en=0 throughout; out_instr=0x1002 and out_pc=8 stable; after release, next is pc=12 with no duplicate and no skip.
- Redirect to 0x43 while pc=16 is pending and out_ready=1 → no transfer in that cycle; rom_addr=0x40; next cycle out_pc=0x40, then 0x44.
- halt_req pulse with a pending response and out_ready=0 for 2 cycles → state DRAIN, no rom_en; after the response is accepted, halted=1 and out_valid=0; redirect to 0 → halted=0 and out_pc=0 next cycle.
- LENGTH=4, run from 0 → pcs 0,4,8,12 with out_fault=0; pc 16 is delivered with out_fault=1, then halted=1 and no further rom_en.
- Assert rst_n=0 mid-stream with out_valid=1 → out_valid, rom_en and halted go to 0 asynchronously; after release, the sequence restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// ============================================================================
//  Module   : fetch_unit_if
//  Purpose  : ROM port-A and decode-handshake bundle of the fetch stage.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic             rom_en;
    logic [WIDTH-1:0] rom_addr;
    logic [WIDTH-1:0] rom_rd;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             halt_req;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_instr;
    logic [WIDTH-1:0] out_pc;
    logic             out_fault;
    logic             halted;

    // Fetch-unit side
    modport master (
        output rom_en, rom_addr, out_valid, out_instr, out_pc, out_fault, halted,
        input  rom_rd, redirect_valid, redirect_pc, halt_req, out_ready
    );

    // ROM / decode / branch-unit side
    modport slave (
        input  rom_en, rom_addr, out_valid, out_instr, out_pc, out_fault, halted,
        output rom_rd, redirect_valid, redirect_pc, halt_req, out_ready
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : PC owner and instruction-fetch stage in front of a 1-cycle ROM.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter int               LENGTH   = 256,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  wire            clk,
    input  wire            rst_n,
    fetch_unit_if.master   bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [WIDTH:0] c_limit = (WIDTH+1)'(LENGTH) << 2;

    state_t           r_state,      w_state_nxt;
    logic [WIDTH-1:0] r_fetch_pc,   w_fetch_pc_nxt;
    logic [WIDTH-1:0] r_resp_pc,    w_resp_pc_nxt;
    logic             r_resp_valid, w_resp_valid_nxt;
    logic             r_resp_fault, w_resp_fault_nxt;
    logic             w_rom_en;
    logic [WIDTH-1:0] w_rom_addr;
    logic [WIDTH-1:0] w_redir_addr;
    logic             w_can_issue;

    function automatic logic f_out_of_range(input logic [WIDTH-1:0] addr);
        return {1'b0, addr} >= c_limit;
    endfunction

    assign w_redir_addr = bus.redirect_pc & ~WIDTH'(3);
    assign w_can_issue  = !r_resp_valid || bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_fetch_pc   <= RESET_PC;
            r_resp_pc    <= RESET_PC;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_resp_pc    <= w_resp_pc_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_fault <= w_resp_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_resp_pc_nxt    = r_resp_pc;
        w_resp_valid_nxt = r_resp_valid;
        w_resp_fault_nxt = r_resp_fault;
        w_rom_en         = 1'b0;
        w_rom_addr       = r_fetch_pc;

        if (bus.redirect_valid) begin
            // Redirect overrides everything and squashes the pending response.
            w_rom_en         = 1'b1;
            w_rom_addr       = w_redir_addr;
            w_resp_valid_nxt = 1'b1;
            w_resp_pc_nxt    = w_redir_addr;
            w_resp_fault_nxt = f_out_of_range(w_redir_addr);
            w_fetch_pc_nxt   = w_redir_addr + WIDTH'(4);
            w_state_nxt      = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.halt_req) begin
                        w_state_nxt = ST_DRAIN;
                        if (bus.out_ready) w_resp_valid_nxt = 1'b0;
                    end else if (w_can_issue) begin
                        w_rom_en         = 1'b1;
                        w_fetch_pc_nxt   = r_fetch_pc + WIDTH'(4);
                        w_resp_valid_nxt = 1'b1;
                        w_resp_pc_nxt    = r_fetch_pc;
                        w_resp_fault_nxt = f_out_of_range(r_fetch_pc);
                        if (f_out_of_range(r_fetch_pc)) w_state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.out_ready) w_resp_valid_nxt = 1'b0;
                    if (!r_resp_valid || bus.out_ready) w_state_nxt = ST_HALT;
                end
                ST_HALT: begin
                    w_resp_valid_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // rst_n gates the enable so the ROM sees no request while reset is held.
    assign bus.rom_en    = rst_n && w_rom_en;
    assign bus.rom_addr  = w_rom_addr;
    assign bus.out_valid = r_resp_valid && !bus.redirect_valid && (r_state != ST_HALT);
    assign bus.out_instr = bus.rom_rd;
    assign bus.out_pc    = r_resp_pc;
    assign bus.out_fault = r_resp_fault;
    assign bus.halted    = (r_state == ST_HALT);

endmodule

`default_nettype wire
